// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 MIPS register file, two combinational read ports, one write port
// Register 0 is never written, so it holds its reset value of zero.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_en;

  assign w_wr_en = we3 && (wa3 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[wa3] <= wd3;
    end
  end

  // The address-zero mux keeps register 0 reading zero regardless of storage.
  assign rd1 = (ra1 == '0) ? '0 : r_regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : r_regs[ra2];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int errors = 0;
  int checks = 0;

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we3  (we3),
    .wa3  (wa3),
    .wd3  (wd3),
    .ra1  (ra1),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    @(posedge clk);
    #1;
    we3 = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    ra1 = a1;
    ra2 = a2;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    ra1 = 5'd5;
    ra2 = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_in rd1: got %h want %h", rd1, 32'h0);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_in rd2: got %h want %h", rd2, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_reads(5'd5, 5'd31);
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_out rd1: got %h want %h", rd1, 32'h0);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_out rd2: got %h want %h", rd2, 32'h0);
    end
  endtask

  task automatic test_basic;
    do_write(5'd5, 32'h12345678);
    set_reads(5'd5, 5'd1);
    checks++;
    if (rd1 !== 32'h12345678) begin
      errors++;
      $display("FAIL basic rd1: got %h want %h", rd1, 32'h12345678);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      errors++;
      $display("FAIL basic rd2: got %h want %h", rd2, 32'h0);
    end
  endtask

  task automatic test_no_alias;
    do_write(5'd10, 32'hDEADBEEF);
    set_reads(5'd10, 5'd5);
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alias rd1: got %h want %h", rd1, 32'hDEADBEEF);
    end
    checks++;
    if (rd2 !== 32'h12345678) begin
      errors++;
      $display("FAIL alias rd2: got %h want %h", rd2, 32'h12345678);
    end
    set_reads(5'd10, 5'd10);
    checks++;
    if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL same_addr: got %h/%h want %h", rd1, rd2, 32'hDEADBEEF);
    end
  endtask

  task automatic test_reg0;
    do_write(5'd0, 32'hFFFFFFFF);
    set_reads(5'd10, 5'd0);
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reg0 rd1: got %h want %h", rd1, 32'hDEADBEEF);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reg0 rd2: got %h want %h", rd2, 32'h0);
    end
  endtask

  task automatic test_we_gating;
    @(negedge clk);
    we3 = 1'b0;
    wa3 = 5'd5;
    wd3 = 32'h0BADF00D;
    @(posedge clk);
    #1;
    @(negedge clk);
    we3 = 1'b0;
    wa3 = 5'bx;
    wd3 = 32'hx;
    @(posedge clk);
    #1;
    set_reads(5'd5, 5'd10);
    checks++;
    if (rd1 !== 32'h12345678) begin
      errors++;
      $display("FAIL we_gate rd1: got %h want %h", rd1, 32'h12345678);
    end
    checks++;
    if (rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL we_gate_x rd2: got %h want %h", rd2, 32'hDEADBEEF);
    end
  endtask

  task automatic test_read_during_write;
    @(negedge clk);
    we3 = 1'b1;
    wa3 = 5'd7;
    wd3 = 32'h00000042;
    ra1 = 5'd7;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL rdw_before rd1: got %h want %h", rd1, 32'h0);
    end
    @(posedge clk);
    #1;
    we3 = 1'b0;
    checks++;
    if (rd1 !== 32'h00000042) begin
      errors++;
      $display("FAIL rdw_after rd1: got %h want %h", rd1, 32'h00000042);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    we3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wa3 = 5'(28 + i);
      wd3 = 32'hA0000000 + 32'(i);
      @(negedge clk);
    end
    we3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_reads(5'(28 + i), 5'(31 - i));
      checks++;
      if (rd1 !== 32'hA0000000 + 32'(i) || rd2 !== 32'hA0000003 - 32'(i)) begin
        errors++;
        $display("FAIL b2b idx %0d: got %h/%h want %h/%h", i, rd1, rd2,
                 32'hA0000000 + 32'(i), 32'hA0000003 - 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid;
    set_reads(5'd5, 5'd10);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%h want %h/%h", rd1, rd2, 32'h0, 32'h0);
    end
    we3 = 1'b1;
    wa3 = 5'd5;
    wd3 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_reads(5'd5, 5'd7);
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_write rd1: got %h want %h", rd1, 32'h0);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid reg7 rd2: got %h want %h", rd2, 32'h0);
    end
    do_write(5'd5, 32'h55AA55AA);
    set_reads(5'd5, 5'd0);
    checks++;
    if (rd1 !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL post_reset_write rd1: got %h want %h", rd1, 32'h55AA55AA);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_alias();
    test_reg0();
    test_we_gating();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
